mem_responder: RTL and testbench

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/riscv_mem_pkg.sv | 17 +
 rtl/mem_responder_if.sv | 19 +
 rtl/mem_responder_array.sv | 27 ++
 rtl/mem_responder.sv | 81 ++++++++
 tb/tb_mem_responder.sv | 167 ++++++++++++++++
 5 files changed

// File: rtl/riscv_mem_pkg.sv
// Shared definitions for the memory responder: FSM encoding, bus widths and
// the request error check.
package riscv_mem_pkg;
  localparam int WORD_W = 32;
  localparam int BE_W   = 4;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  localparam logic [1:0] ALIGN_MASK = 2'b11;

  // Misaligned byte address, or word index beyond the backing store.
  function automatic logic addr_err(input logic [WORD_W-1:0] addr, input int unsigned depth);
    return ((addr[1:0] & ALIGN_MASK) != 2'b00) || ({2'b00, addr[WORD_W-1:2]} >= depth);
  endfunction
endpackage

// File: rtl/mem_responder_if.sv
// Request/response handshake bundle between an initiator and mem_responder.
interface mem_responder_if;
  import riscv_mem_pkg::*;
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [WORD_W-1:0] req_addr;
  logic [WORD_W-1:0] req_wdata;
  logic [BE_W-1:0]   req_be;
  logic              resp_valid;
  logic              resp_ready;
  logic [WORD_W-1:0] resp_rdata;
  logic              resp_err;

  modport master (output req_valid, req_we, req_addr, req_wdata, req_be, resp_ready,
                  input  req_ready, resp_valid, resp_rdata, resp_err);
  modport slave  (input  req_valid, req_we, req_addr, req_wdata, req_be, resp_ready,
                  output req_ready, resp_valid, resp_rdata, resp_err);
endinterface

// File: rtl/mem_responder_array.sv
// Single-port synchronous RAM, byte write enables, registered read.
import riscv_mem_pkg::*;

module mem_array #(
  parameter int DEPTH_WORDS = 256,
  parameter int AW          = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [BE_W-1:0]   be,
  input  logic [AW-1:0]     addr,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);
  logic [WORD_W-1:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        for (int i = 0; i < BE_W; i++)
          if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
      rdata <= mem[addr];
    end
  end
endmodule

// File: rtl/mem_responder.sv
// Single-outstanding memory responder: accept, wait WAIT_CYCLES, then hold the
// response until the initiator takes it.
import riscv_mem_pkg::*;

module mem_responder #(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic           clk,
  input  logic           rst,
  mem_responder_if.slave bus
);
  localparam int         AW       = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [3:0] CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;
  localparam logic       NO_WAIT  = (WAIT_CYCLES == 0);

  logic [1:0]        state;
  logic [3:0]        cnt;
  logic              we_q, err_q;
  logic [WORD_W-1:0] addr_q, wdata_q;
  logic [BE_W-1:0]   be_q;
  logic [WORD_W-1:0] ram_rdata;

  logic              accept, enter_resp, a_we, a_err;
  logic [WORD_W-1:0] a_addr, a_wdata;
  logic [BE_W-1:0]   a_be;

  assign accept     = (state == IDLE) && bus.req_valid;
  assign enter_resp = (accept && NO_WAIT) || ((state == WAIT) && (cnt == 4'd0));

  // With no wait the array is accessed on the accept edge itself, before the
  // latch holds the request, so feed it the live inputs while idle.
  assign a_we    = (state == IDLE) ? bus.req_we    : we_q;
  assign a_addr  = (state == IDLE) ? bus.req_addr  : addr_q;
  assign a_wdata = (state == IDLE) ? bus.req_wdata : wdata_q;
  assign a_be    = (state == IDLE) ? bus.req_be    : be_q;
  assign a_err   = addr_err(a_addr, DEPTH_WORDS);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
    end else begin
      if (enter_resp) err_q <= a_err;
      case (state)
        IDLE: if (accept) begin
          we_q    <= bus.req_we;
          addr_q  <= bus.req_addr;
          wdata_q <= bus.req_wdata;
          be_q    <= bus.req_be;
          cnt     <= CNT_INIT;
          state   <= NO_WAIT ? RESP : WAIT;
        end
        WAIT: if (cnt == 4'd0) state <= RESP;
              else             cnt   <= cnt - 4'd1;
        RESP: if (bus.resp_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  mem_array #(.DEPTH_WORDS(DEPTH_WORDS), .AW(AW)) u_array (
    .clk   (clk),
    .en    (enter_resp && !a_err),
    .we    (a_we),
    .be    (a_be),
    .addr  (a_addr[AW+1:2]),
    .wdata (a_wdata),
    .rdata (ram_rdata)
  );

  assign bus.req_ready  = (state == IDLE);
  assign bus.resp_valid = (state == RESP);
  assign bus.resp_err   = err_q;
  assign bus.resp_rdata = ((state == RESP) && !err_q && !we_q) ? ram_rdata : '0;
endmodule

// File: tb/tb_mem_responder.sv
// Randomized and directed bench for mem_responder with WAIT_CYCLES=2 and 0,
// checked against a word-array model of the store.
module tb_mem_responder;
  logic        clk = 1'b0;
  logic        rst;
  logic        sel;
  logic        req_valid, req_we, resp_ready;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_be;
  logic        req_ready, resp_valid, resp_err;
  logic [31:0] resp_rdata;

  int checks = 0;
  int failures = 0;
  logic [31:0] model [2][256];

  always #5 clk = ~clk;

  mem_responder_if if2();
  mem_responder_if if0();

  assign if2.req_valid  = req_valid & ~sel;
  assign if0.req_valid  = req_valid & sel;
  assign if2.resp_ready = resp_ready & ~sel;
  assign if0.resp_ready = resp_ready & sel;
  assign if2.req_we = req_we;       assign if0.req_we = req_we;
  assign if2.req_addr = req_addr;   assign if0.req_addr = req_addr;
  assign if2.req_wdata = req_wdata; assign if0.req_wdata = req_wdata;
  assign if2.req_be = req_be;       assign if0.req_be = req_be;

  assign req_ready  = sel ? if0.req_ready  : if2.req_ready;
  assign resp_valid = sel ? if0.resp_valid : if2.resp_valid;
  assign resp_err   = sel ? if0.resp_err   : if2.resp_err;
  assign resp_rdata = sel ? if0.resp_rdata : if2.resp_rdata;

  mem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(2)) dut2 (.clk(clk), .rst(rst), .bus(if2));
  mem_responder #(.DEPTH_WORDS(256), .WAIT_CYCLES(0)) dut0 (.clk(clk), .rst(rst), .bus(if0));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One full transaction; model gives expected latency, data and error.
  task automatic txn(input logic s, input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [3:0] be, input int hold, input logic early);
    logic [31:0] exp_rd;
    logic        exp_err;
    int          lat, w, exp_lat;
    exp_err = (addr[1:0] != 2'b00) || (addr >= 32'd1024);
    w       = int'(addr[9:2]);
    exp_lat = s ? 0 : 2;
    exp_rd  = 32'd0;
    if (!exp_err && !we) exp_rd = model[s][w];
    if (!exp_err && we)
      for (int i = 0; i < 4; i++)
        if (be[i]) model[s][w][8*i +: 8] = wdata[8*i +: 8];

    @(negedge clk);
    sel = s; req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_be = be;
    resp_ready = 1'b0;
    check("req_ready_idle", 32'(req_ready), 32'd1);
    @(posedge clk); #1;
    // Garbage on the request bus must not disturb the latched request.
    req_valid = 1'($urandom); req_we = 1'($urandom); req_addr = $urandom;
    req_wdata = $urandom; req_be = 4'($urandom);
    resp_ready = early;
    lat = 0;
    while (!resp_valid && lat < 40) begin
      check("req_ready_wait", 32'(req_ready), 32'd0);
      @(posedge clk); #1;
      lat++;
    end
    check("latency", 32'(lat), 32'(exp_lat));
    check("rdata", resp_rdata, exp_rd);
    check("err", 32'(resp_err), 32'(exp_err));
    check("req_ready_resp", 32'(req_ready), 32'd0);
    if (!early) begin
      for (int h = 0; h < hold; h++) begin
        @(posedge clk); #1;
        check("hold_valid", 32'(resp_valid), 32'd1);
        check("hold_rdata", resp_rdata, exp_rd);
        check("hold_err", 32'(resp_err), 32'(exp_err));
        check("hold_req_ready", 32'(req_ready), 32'd0);
      end
      resp_ready = 1'b1;
    end
    @(posedge clk); #1;
    resp_ready = 1'b0; req_valid = 1'b0;
    check("idle_valid", 32'(resp_valid), 32'd0);
    check("idle_req_ready", 32'(req_ready), 32'd1);
  endtask

  initial begin
    rst = 1'b1; sel = 1'b0; req_valid = 1'b0; req_we = 1'b0; resp_ready = 1'b0;
    req_addr = '0; req_wdata = '0; req_be = '0;
    #1;
    check("rst_valid2", 32'(if2.resp_valid), 32'd0);
    check("rst_ready2", 32'(if2.req_ready), 32'd1);
    check("rst_err2", 32'(if2.resp_err), 32'd0);
    check("rst_rdata2", if2.resp_rdata, 32'd0);
    check("rst_valid0", 32'(if0.resp_valid), 32'd0);
    check("rst_rdata0", if0.resp_rdata, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < 64; i++) txn(1'b0, 1'b1, 32'(i * 4), $urandom, 4'hF, 0, 1'b0);
    for (int i = 0; i < 16; i++) txn(1'b1, 1'b1, 32'(i * 4), $urandom, 4'hF, 0, 1'b0);

    // Write then read back, WAIT_CYCLES=2
    txn(1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, 1'b0);
    txn(1'b0, 1'b0, 32'h10, 32'h0, 4'h0, 0, 1'b0);
    // Partial byte write
    txn(1'b0, 1'b1, 32'h20, 32'hFFFFFFFF, 4'hF, 0, 1'b0);
    txn(1'b0, 1'b1, 32'h20, 32'h00000000, 4'b0101, 0, 1'b0);
    txn(1'b0, 1'b0, 32'h20, 32'h0, 4'hF, 0, 1'b0);
    // Errors: misaligned read, out-of-range write, then word 0 untouched
    txn(1'b0, 1'b0, 32'h22, 32'h0, 4'hF, 0, 1'b0);
    txn(1'b0, 1'b1, 32'h400, 32'hA5A5A5A5, 4'hF, 0, 1'b0);
    txn(1'b0, 1'b0, 32'h000, 32'h0, 4'hF, 0, 1'b0);
    // Zero byte-enable write, then long hold on a read
    txn(1'b0, 1'b1, 32'h40, 32'h13572468, 4'h0, 0, 1'b0);
    txn(1'b0, 1'b0, 32'h40, 32'h0, 4'h0, 5, 1'b0);

    // Reset one cycle into WAIT discards the pending write
    @(negedge clk);
    sel = 1'b0; req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h30;
    req_wdata = 32'h12345678; req_be = 4'hF;
    @(posedge clk); #1 req_valid = 1'b0;
    @(posedge clk); #1 rst = 1'b1;
    #1;
    check("mid_rst_valid", 32'(resp_valid), 32'd0);
    check("mid_rst_err", 32'(resp_err), 32'd0);
    check("mid_rst_rdata", resp_rdata, 32'd0);
    check("mid_rst_ready", 32'(req_ready), 32'd1);
    @(posedge clk); #1 rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check("no_resp_after_rst", 32'(resp_valid), 32'd0);
    end
    txn(1'b0, 1'b0, 32'h30, 32'h0, 4'hF, 0, 1'b0);

    // Zero-wait read and read-after-write
    txn(1'b1, 1'b0, 32'h8, 32'h0, 4'hF, 0, 1'b0);
    txn(1'b1, 1'b1, 32'h8, 32'hCAFEF00D, 4'b1100, 0, 1'b1);
    txn(1'b1, 1'b0, 32'h8, 32'h0, 4'hF, 2, 1'b0);

    for (int n = 0; n < 200; n++) begin
      logic        s;
      logic [31:0] a;
      int          r;
      s = 1'($urandom);
      a = 32'($urandom_range(s ? 15 : 63, 0) * 4);
      r = int'($urandom_range(9, 0));
      if (r == 0) a = a | 32'($urandom_range(3, 1));
      if (r == 1) a = 32'h400 + 32'($urandom_range(4000, 0));
      txn(s, 1'($urandom), a, $urandom, 4'($urandom), int'($urandom_range(3, 0)),
          ($urandom_range(2, 0) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
